mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit between the EX/MEM and MEM/WB pipeline registers.
//  - Loads: byte/half/word, sign/zero extended. Stores: byte-lane enables.
//  - Variable-latency data memory behind a req/rsp handshake; pipeline stalls until it completes.
//  - Drives the RegWrite/WriteAddr/MEMOut inputs of MEM/WB.
// PARAMETERS
//  ADDR_W  32  width of dmem_addr; data path is fixed at 32 bits
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  in_valid       in   1       EX/MEM holds a valid instruction
//  in_MemRead     in   1       load
//  in_MemWrite    in   1       store (never set together with in_MemRead)
//  in_MemSize     in   2       0=byte 1=half 2=word (3 treated as word)
//  in_MemSigned   in   1       sign-extend load result
//  in_RegWrite    in   1       instruction writes the register file
//  in_WriteAddr   in   5       destination register
//  in_ALUOut      in   32      ALU result / effective address
//  in_StoreData   in   32      store data (low bits significant for byte/half)
//  dmem_req       out  1       request pending, held until dmem_rsp
//  dmem_we        out  1       1=write
//  dmem_addr      out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dmem_wdata     out  32      lane-replicated store data
//  dmem_be        out  4       byte enables
//  dmem_rsp       in   1       one-cycle completion pulse
//  dmem_rdata     in   32      read word, valid with dmem_rsp
//  stall          out  1       freeze PC, IF/ID, ID/EX, EX/MEM
//  out_RegWrite   out  1       to MEM/WB
//  out_WriteAddr  out  5       to MEM/WB
//  out_MEMOut     out  32      to MEM/WB: load data or ALU result
//  mem_exc        out  1       misaligned-access pulse (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; captured request regs cleared; dmem_req=0, dmem_we=0,
//    dmem_be=0, stall=0, out_RegWrite=0, mem_exc=0. A dmem_rsp arriving in IDLE is ignored.
//  - mem_op = in_valid & (in_MemRead | in_MemWrite).
//  - IDLE, !mem_op: combinational pass-through; out_RegWrite=in_valid&in_RegWrite,
//    out_MEMOut=in_ALUOut, stall=0.
//  - IDLE, mem_op: stall=1, out_RegWrite=0; at the edge, capture we/addr/be/wdata/size/signed/
//    RegWrite/WriteAddr and go to BUSY.
//  - BUSY: dmem_* driven from captured registers, dmem_req=1. stall=!dmem_rsp; out_RegWrite=0
//    until dmem_rsp.
//  - BUSY & dmem_rsp (completion cycle): stall=0.
//    Load: out_RegWrite=captured RegWrite; out_MEMOut=extracted dmem_rdata.
//    Store: out_RegWrite=0.
//    Next state IDLE. EX/MEM advances on this edge.
//  - Latency: memory op occupies >=2 cycles (capture + >=1 BUSY); stall cycles = 1 + BUSY cycles.
//  - Lanes: byte be=4'b0001<<a[1:0], wdata={4{d[7:0]}};
//    half be=a[1]?4'b1100:4'b0011, wdata={2{d[15:0]}};
//    word be=4'b1111, wdata=d.
//    Load extraction selects the same lane, then sign/zero extends to 32 bits.
//  - No back-to-back overlap: a new request is captured only from IDLE.
//  - Reset mid-BUSY aborts: dmem_req drops immediately; the memory side must tolerate
//    an abandoned request.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//    - Misaligned = half with a[0]=1, or word with a[1:0]!=0.
//    - Misaligned mem_op in IDLE: no capture, no dmem_req, stall=0, out_RegWrite=0,
//      mem_exc=1 for that cycle.
//  Undefined: mem_exc tied 0; a[0] ignored for half, a[1:0] ignored for word (aligned down).
// STRUCTURE
//  - Package mem_pkg: MEM_SZ_BYTE/HALF/WORD encodings; state enum {IDLE,BUSY}.
//  - Sub-module mem_lane_align (combinational): size+addr+store data -> be/wdata;
//    size+addr+signed+rdata -> load value. Used twice (store path, load path).
//  - Top holds the FSM and capture registers.
// TESTING
//  1 Reset: hold rst=0 with in_* active -> dmem_req=0, stall=0, out_RegWrite=0, mem_exc=0.
//  2 ALU op: in_ALUOut=5, RegWrite=1, WriteAddr=3 -> same cycle out_MEMOut=5,
//    out_RegWrite=1, stall=0.
//  3 Word load @0x100, rsp 3 cycles after req, rdata=0xDEADBEEF:
//    - stall high 4 cycles, dmem_be=4'hF;
//    - rsp cycle: out_MEMOut=0xDEADBEEF, out_RegWrite=1, stall=0.
//  4 Byte load @0x103, rdata=0x80000000:
//    - signed -> 0xFFFFFF80; unsigned -> 0x00000080;
//    - half signed @0x102, rdata=0x8001xxxx -> 0xFFFF8001.
//  5 Half store @0x202, data=0x00001234:
//    - dmem_addr=0x200, be=4'b1100, wdata=0x12341234, we=1;
//    - rsp cycle out_RegWrite=0.
//  6 Word load @0x101:
//    - with MEM_MISALIGN_TRAP_EN: mem_exc=1 one cycle, dmem_req never asserted;
//    - without: dmem_addr=0x100.
//    Also: rst=0 mid-BUSY -> dmem_req=0 immediately; later dmem_rsp ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: access sizes and FSM states.
package mem_pkg;

  localparam logic [1:0] MemSzByte = 2'd0;
  localparam logic [1:0] MemSzHalf = 2'd1;
  localparam logic [1:0] MemSzWord = 2'd2;

  typedef enum logic {
    StIdle,
    StBusy
  } mem_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/rsp bus; master is the access unit, slave is the memory.
interface mem_access_unit_if #(
  parameter int unsigned AddrW = 32
) ();

  logic             req;
  logic             we;
  logic [AddrW-1:0] addr;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             rsp;
  logic [31:0]      rdata;

  modport master (output req, we, addr, wdata, be, input rsp, rdata);
  modport slave  (input req, we, addr, wdata, be, output rsp, rdata);

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/enables from size+addr, and load extraction with sign/zero extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rd_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] rd_shifted;
  logic [15:0] rd_half;

  assign rd_shifted = rd_data_i >> {addr_lo_i, 3'b000};
  assign rd_half    = addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];

  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = st_data_i;
    ld_data_o = rd_data_i;
    case (size_i)
      MemSzByte: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sign_i & rd_shifted[7]}}, rd_shifted[7:0]};
      end
      MemSzHalf: begin
        // a[0] is ignored for halves; misalignment is trapped upstream when enabled.
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sign_i & rd_half[15]}}, rd_half};
      end
      default: begin
        be_o      = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = rd_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: stalls the pipeline around a variable-latency data-memory access.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses via mem_exc_o.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned AddrW = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  input  logic                in_mem_read_i,
  input  logic                in_mem_write_i,
  input  logic [1:0]          in_mem_size_i,
  input  logic                in_mem_signed_i,
  input  logic                in_reg_write_i,
  input  logic [4:0]          in_write_addr_i,
  input  logic [31:0]         in_alu_out_i,
  input  logic [31:0]         in_store_data_i,
  mem_access_unit_if.master   dmem,
  output logic                stall_o,
  output logic                out_reg_write_o,
  output logic [4:0]          out_write_addr_o,
  output logic [31:0]         out_mem_out_o,
  output logic                mem_exc_o
);

  mem_state_e       state_q, state_d;
  logic             capture;
  logic             mem_op;
  logic             misaligned;

  logic             we_q;
  logic [AddrW-1:0] addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic             reg_write_q;
  logic [4:0]       write_addr_q;

  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      st_ld_data;
  logic [3:0]       ld_be;
  logic [31:0]      ld_wdata;
  logic [31:0]      ld_data;
  logic             unused_lane;

  assign mem_op = in_valid_i & (in_mem_read_i | in_mem_write_i);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((in_mem_size_i == MemSzHalf) & in_alu_out_i[0]) |
                      (in_mem_size_i[1] & (|in_alu_out_i[1:0]));
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_align u_store_align (
    .size_i    (in_mem_size_i),
    .addr_lo_i (in_alu_out_i[1:0]),
    .sign_i    (in_mem_signed_i),
    .st_data_i (in_store_data_i),
    .rd_data_i (dmem.rdata),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .ld_data_o (st_ld_data)
  );

  mem_lane_align u_load_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .sign_i    (signed_q),
    .st_data_i (wdata_q),
    .rd_data_i (dmem.rdata),
    .be_o      (ld_be),
    .wdata_o   (ld_wdata),
    .ld_data_o (ld_data)
  );

  // Each instance only feeds one direction; the other half of its outputs is dropped.
  assign unused_lane = ^{st_ld_data, ld_be, ld_wdata};

  always_comb begin
    state_d          = state_q;
    capture          = 1'b0;
    stall_o          = 1'b0;
    out_reg_write_o  = 1'b0;
    out_write_addr_o = in_write_addr_i;
    out_mem_out_o    = in_alu_out_i;
    mem_exc_o        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op && misaligned) begin
          mem_exc_o = 1'b1;
        end else if (mem_op) begin
          stall_o = 1'b1;
          capture = 1'b1;
          state_d = StBusy;
        end else begin
          out_reg_write_o = in_valid_i & in_reg_write_i;
        end
      end
      StBusy: begin
        stall_o          = ~dmem.rsp;
        out_write_addr_o = write_addr_q;
        if (dmem.rsp) begin
          out_reg_write_o = ~we_q & reg_write_q;
          out_mem_out_o   = we_q ? in_alu_out_i : ld_data;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs stay quiet while reset is asserted, even with a live EX/MEM stage.
    if (!rst_ni) begin
      stall_o         = 1'b0;
      out_reg_write_o = 1'b0;
      mem_exc_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      size_q       <= MemSzByte;
      signed_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        we_q         <= in_mem_write_i;
        addr_q       <= in_alu_out_i[AddrW-1:0];
        be_q         <= st_be;
        wdata_q      <= st_wdata;
        size_q       <= in_mem_size_i;
        signed_q     <= in_mem_signed_i;
        reg_write_q  <= in_reg_write_i;
        write_addr_q <= in_write_addr_i;
      end
    end
  end

  assign dmem.req   = (state_q == StBusy);
  assign dmem.we    = (state_q == StBusy) & we_q;
  assign dmem.addr  = {addr_q[AddrW-1:2], 2'b00};
  assign dmem.be    = (state_q == StBusy) ? be_q : 4'b0000;
  assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboard of expected MEM/WB results per memory transaction.
module tb_mem_access_unit;

  typedef struct packed {
    logic [31:0] mem_out;
    logic        reg_write;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        we;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [1:0]  in_mem_size;
  logic        in_mem_signed;
  logic        in_reg_write;
  logic [4:0]  in_write_addr;
  logic [31:0] in_alu_out;
  logic [31:0] in_store_data;
  logic        stall;
  logic        out_reg_write;
  logic [4:0]  out_write_addr;
  logic [31:0] out_mem_out;
  logic        mem_exc;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  mem_access_unit_if #(.AddrW(32)) dmem_bus ();

  mem_access_unit #(.AddrW(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .in_valid_i       (in_valid),
    .in_mem_read_i    (in_mem_read),
    .in_mem_write_i   (in_mem_write),
    .in_mem_size_i    (in_mem_size),
    .in_mem_signed_i  (in_mem_signed),
    .in_reg_write_i   (in_reg_write),
    .in_write_addr_i  (in_write_addr),
    .in_alu_out_i     (in_alu_out),
    .in_store_data_i  (in_store_data),
    .dmem             (dmem_bus),
    .stall_o          (stall),
    .out_reg_write_o  (out_reg_write),
    .out_write_addr_o (out_write_addr),
    .out_mem_out_o    (out_mem_out),
    .mem_exc_o        (mem_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One memory transaction; lat = cycles from dmem_req rising to the dmem_rsp pulse.
  task automatic mem_txn(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int lat, input exp_t e);
    exp_t got;
    int   stall_cnt;
    stall_cnt = 0;
    @(negedge clk);
    in_valid      = 1'b1;
    in_mem_read   = ~we;
    in_mem_write  = we;
    in_mem_size   = sz;
    in_mem_signed = sgn;
    in_reg_write  = 1'b1;
    in_write_addr = 5'd7;
    in_alu_out    = addr;
    in_store_data = sdata;
    sb_q.push_back(e);
    #1;
    check({tag, ".cap_stall"}, stall, 1);
    check({tag, ".cap_req"}, dmem_bus.req, 0);
    check({tag, ".cap_rw"}, out_reg_write, 0);
    if (stall) stall_cnt++;
    @(negedge clk);
    #1;
    check({tag, ".req"}, dmem_bus.req, 1);
    check({tag, ".we"}, dmem_bus.we, e.we);
    check({tag, ".addr"}, dmem_bus.addr, e.addr);
    check({tag, ".be"}, dmem_bus.be, e.be);
    if (e.we) check({tag, ".wdata"}, dmem_bus.wdata, e.wdata);
    for (int i = 0; i < lat; i++) begin
      if (stall) stall_cnt++;
      check({tag, ".busy_rw"}, out_reg_write, 0);
      @(negedge clk);
      #1;
    end
    dmem_bus.rsp   = 1'b1;
    dmem_bus.rdata = rdata;
    #1;
    got = sb_q.pop_front();
    check({tag, ".rsp_stall"}, stall, 0);
    check({tag, ".rsp_rw"}, out_reg_write, got.reg_write);
    check({tag, ".rsp_wa"}, out_write_addr, 7);
    if (!got.we) check({tag, ".rsp_data"}, out_mem_out, got.mem_out);
    check({tag, ".stall_cycles"}, stall_cnt, lat + 1);
    @(negedge clk);
    dmem_bus.rsp = 1'b0;
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    #1;
    check({tag, ".idle_req"}, dmem_bus.req, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b1;
    in_mem_read    = 1'b1;
    in_mem_write   = 1'b0;
    in_mem_size    = 2'd2;
    in_mem_signed  = 1'b0;
    in_reg_write   = 1'b1;
    in_write_addr  = 5'd1;
    in_alu_out     = 32'h100;
    in_store_data  = 32'h0;
    dmem_bus.rsp   = 1'b0;
    dmem_bus.rdata = 32'h0;

    // Reset held with an active load on the inputs.
    repeat (2) @(negedge clk);
    #1;
    check("rst.req", dmem_bus.req, 0);
    check("rst.stall", stall, 0);
    check("rst.rw", out_reg_write, 0);
    check("rst.exc", mem_exc, 0);
    check("rst.be", dmem_bus.be, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_mem_read = 1'b0;
    rst_n = 1'b1;

    // ALU pass-through.
    @(negedge clk);
    in_valid = 1'b1; in_alu_out = 32'd5; in_reg_write = 1'b1; in_write_addr = 5'd3;
    #1;
    check("alu.out", out_mem_out, 5);
    check("alu.rw", out_reg_write, 1);
    check("alu.wa", out_write_addr, 3);
    check("alu.stall", stall, 0);
    check("alu.req", dmem_bus.req, 0);

    mem_txn("lw100", 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 3,
            '{mem_out: 32'hDEADBEEF, reg_write: 1, be: 4'hF, wdata: 0, addr: 32'h100, we: 0});
    mem_txn("lb103s", 0, 2'd0, 1, 32'h103, 0, 32'h80000000, 1,
            '{mem_out: 32'hFFFFFF80, reg_write: 1, be: 4'b1000, wdata: 0, addr: 32'h100, we: 0});
    mem_txn("lbu103", 0, 2'd0, 0, 32'h103, 0, 32'h80000000, 2,
            '{mem_out: 32'h00000080, reg_write: 1, be: 4'b1000, wdata: 0, addr: 32'h100, we: 0});
    mem_txn("lh102s", 0, 2'd1, 1, 32'h102, 0, 32'h80015555, 1,
            '{mem_out: 32'hFFFF8001, reg_write: 1, be: 4'b1100, wdata: 0, addr: 32'h100, we: 0});
    mem_txn("lhu100", 0, 2'd1, 0, 32'h100, 0, 32'h1234F00D, 1,
            '{mem_out: 32'h0000F00D, reg_write: 1, be: 4'b0011, wdata: 0, addr: 32'h100, we: 0});
    mem_txn("sh202", 1, 2'd1, 0, 32'h202, 32'h00001234, 0, 2,
            '{mem_out: 0, reg_write: 0, be: 4'b1100, wdata: 32'h12341234, addr: 32'h200, we: 1});
    mem_txn("sb201", 1, 2'd0, 0, 32'h201, 32'h5A5A56AB, 0, 1,
            '{mem_out: 0, reg_write: 0, be: 4'b0010, wdata: 32'hABABABAB, addr: 32'h200, we: 1});

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_size = 2'd2; in_alu_out = 32'h101;
    #1;
    check("mis.exc", mem_exc, 1);
    check("mis.stall", stall, 0);
    check("mis.rw", out_reg_write, 0);
    @(negedge clk);
    in_valid = 1'b0; in_mem_read = 1'b0;
    #1;
    check("mis.req", dmem_bus.req, 0);
    check("mis.exc_drop", mem_exc, 0);
`else
    mem_txn("lw101", 0, 2'd2, 0, 32'h101, 0, 32'hCAFEF00D, 1,
            '{mem_out: 32'hCAFEF00D, reg_write: 1, be: 4'hF, wdata: 0, addr: 32'h100, we: 0});
`endif

    // Reset while BUSY aborts the request; a late response must be ignored.
    @(negedge clk);
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_size = 2'd2; in_alu_out = 32'h300;
    @(negedge clk);
    #1;
    check("abort.busy_req", dmem_bus.req, 1);
    rst_n = 1'b0;
    #1;
    check("abort.req", dmem_bus.req, 0);
    check("abort.stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0; in_mem_read = 1'b0; in_alu_out = 32'h44;
    dmem_bus.rsp = 1'b1; dmem_bus.rdata = 32'h11111111;
    #1;
    check("late.rw", out_reg_write, 0);
    check("late.out", out_mem_out, 32'h44);
    check("late.stall", stall, 0);
    @(negedge clk);
    dmem_bus.rsp = 1'b0;
    in_valid = 1'b1; in_alu_out = 32'h9; in_write_addr = 5'd12;
    #1;
    check("post.req", dmem_bus.req, 0);
    check("post.rw", out_reg_write, 1);
    check("post.out", out_mem_out, 32'h9);
    check("sb.empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
